bank_ram_xbar: RTL and testbench



---
 rtl/bank_ram_xbar.sv | 218 +++++++++++++++++++++
 tb/tb_bank_ram_xbar.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_ram_xbar.sv
// Multi-slot, multi-bank scratchpad crossbar with per-bank round-robin arbitration and built-in storage.
// Latency: reads return on the requesting slot RAM_LATENCY cycles after accept; writes have no response.
// Backpressure: req_ready is a combinational per-slot grant; denied slots retry and are counted in conflict_cnt.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/ready/we        per-slot request handshake and write enable
//   req_bank/addr/wdata       packed per-slot bank index, row address and write data
//   rsp_valid/rdata/err       per-slot read response (err = bank index out of range)
//   conflict_cnt              saturating count of denied slot-cycles
module bank_ram_xbar #(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_BANKS   = 5,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 2,
  parameter int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_SLOTS-1:0]            req_valid,
  output logic [NUM_SLOTS-1:0]            req_ready,
  input  logic [NUM_SLOTS-1:0]            req_we,
  input  logic [NUM_SLOTS*BANK_W-1:0]     req_bank,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_SLOTS-1:0]            rsp_valid,
  output logic [NUM_SLOTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic [NUM_SLOTS-1:0]            rsp_err,
  output logic [15:0]                     conflict_cnt
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  // Unpacked per-slot views of the packed request buses
  logic [BANK_W-1:0]     slot_bank  [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] slot_addr  [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] slot_wdata [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_oor;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_unpack
    assign slot_bank[s]  = req_bank[s*BANK_W +: BANK_W];
    assign slot_addr[s]  = req_addr[s*ADDR_WIDTH +: ADDR_WIDTH];
    assign slot_wdata[s] = req_wdata[s*DATA_WIDTH +: DATA_WIDTH];
    assign slot_oor[s]   = (32'(slot_bank[s]) >= 32'(NUM_BANKS));
  end

  // Arbitration
  logic [SLOT_W-1:0]    rr_ptr   [NUM_BANKS];
  logic [NUM_SLOTS-1:0] cand     [NUM_BANKS];
  logic [NUM_BANKS-1:0] gnt_vld;
  logic [SLOT_W-1:0]    gnt_slot [NUM_BANKS];
  logic [NUM_SLOTS-1:0] slot_gnt;

  // Candidates are gated by rstn so nothing is granted (or written) while in reset.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cand[b] = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        cand[b][s] = rstn && req_valid[s] && (slot_bank[s] == BANK_W'(b));
      end
    end
  end

  // First candidate at or after rr_ptr, wrapping modulo NUM_SLOTS.
  always_comb begin
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_vld[b]  = 1'b0;
      gnt_slot[b] = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        idx = SLOT_W'((int'(rr_ptr[b]) + i) % NUM_SLOTS);
        if (!gnt_vld[b] && cand[b][idx]) begin
          gnt_vld[b]  = 1'b1;
          gnt_slot[b] = idx;
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_gnt[s] = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gnt_vld[b] && (gnt_slot[b] == SLOT_W'(s))) slot_gnt[s] = 1'b1;
      end
    end
  end

  // Out-of-range requests bypass the banks and are always accepted.
  assign req_ready = rstn ? (slot_gnt | (req_valid & slot_oor)) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gnt_vld[b]) begin
          if (gnt_slot[b] == SLOT_W'(NUM_SLOTS - 1)) rr_ptr[b] <= '0;
          else                                       rr_ptr[b] <= gnt_slot[b] + 1'b1;
        end
      end
    end
  end

  // Bank storage: one single-port array per bank, output register is read stage 1
  logic [DATA_WIDTH-1:0] bank_rdat [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_we;

    assign b_addr  = slot_addr[gnt_slot[b]];
    assign b_wdata = slot_wdata[gnt_slot[b]];
    assign b_we    = req_we[gnt_slot[b]];

    always_ff @(posedge clk) begin
      if (gnt_vld[b]) begin
        if (b_we) mem[b_addr] <= b_wdata;
        else      rd_q        <= mem[b_addr];
      end
    end

    assign bank_rdat[b] = rd_q;
  end

  // Stage 1 per-slot tracking: which bank's output register holds this slot's data.
  logic [NUM_SLOTS-1:0]  s1_vld;
  logic [NUM_SLOTS-1:0]  s1_err;
  logic [BANK_W-1:0]     s1_bank [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] s1_dat  [NUM_SLOTS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld <= '0;
      s1_err <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) s1_bank[s] <= '0;
    end else begin
      s1_vld <= req_ready & ~req_we;
      s1_err <= req_ready & ~req_we & slot_oor;
      for (int s = 0; s < NUM_SLOTS; s++) s1_bank[s] <= slot_bank[s];
    end
  end

  // Data is forced to zero unless a valid in-range read is in this stage, so
  // error responses and idle cycles show rdata=0 without resetting the RAM.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      s1_dat[s] = '0;
      if (s1_vld[s] && !s1_err[s]) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (s1_bank[s] == BANK_W'(b)) s1_dat[s] = bank_rdat[b];
        end
      end
    end
  end

  // Stages 2..RAM_LATENCY
  if (RAM_LATENCY == 1) begin : g_lat1
    assign rsp_valid = s1_vld;
    assign rsp_err   = s1_err;
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_out
      assign rsp_rdata[s*DATA_WIDTH +: DATA_WIDTH] = s1_dat[s];
    end
  end else begin : g_pipe
    logic [NUM_SLOTS-1:0]  p_vld [RAM_LATENCY-1];
    logic [NUM_SLOTS-1:0]  p_err [RAM_LATENCY-1];
    logic [DATA_WIDTH-1:0] p_dat [RAM_LATENCY-1][NUM_SLOTS];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k < RAM_LATENCY - 1; k++) begin
          p_vld[k] <= '0;
          p_err[k] <= '0;
          for (int s = 0; s < NUM_SLOTS; s++) p_dat[k][s] <= '0;
        end
      end else begin
        p_vld[0] <= s1_vld;
        p_err[0] <= s1_err;
        for (int s = 0; s < NUM_SLOTS; s++) p_dat[0][s] <= s1_dat[s];
        for (int k = 1; k < RAM_LATENCY - 1; k++) begin
          p_vld[k] <= p_vld[k-1];
          p_err[k] <= p_err[k-1];
          for (int s = 0; s < NUM_SLOTS; s++) p_dat[k][s] <= p_dat[k-1][s];
        end
      end
    end

    assign rsp_valid = p_vld[RAM_LATENCY-2];
    assign rsp_err   = p_err[RAM_LATENCY-2];
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_out
      assign rsp_rdata[s*DATA_WIDTH +: DATA_WIDTH] = p_dat[RAM_LATENCY-2][s];
    end
  end

  // Conflict counter: add the number of denied slots, clamp at all-ones.
  logic [NUM_SLOTS-1:0] denied;
  logic [16:0]          cnt_sum;

  assign denied = req_valid & ~req_ready;

  always_comb begin
    cnt_sum = {1'b0, conflict_cnt};
    for (int s = 0; s < NUM_SLOTS; s++) cnt_sum = cnt_sum + 17'(denied[s]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     conflict_cnt <= '0;
    else if (cnt_sum > 17'h0FFFF)  conflict_cnt <= 16'hFFFF;
    else                           conflict_cnt <= cnt_sum[15:0];
  end

endmodule

// File: tb/tb_bank_ram_xbar.sv
// Directed self-checking bench for bank_ram_xbar with default parameters
// (4 slots, 5 banks, 9-bit rows, 32-bit words, read latency 2).
module tb_bank_ram_xbar;

  localparam int NS = 4;
  localparam int BW = 3;
  localparam int AW = 9;
  localparam int DW = 32;

  logic             clk;
  logic             rstn;
  logic [NS-1:0]    req_valid;
  logic [NS-1:0]    req_ready;
  logic [NS-1:0]    req_we;
  logic [NS*BW-1:0] req_bank;
  logic [NS*AW-1:0] req_addr;
  logic [NS*DW-1:0] req_wdata;
  logic [NS-1:0]    rsp_valid;
  logic [NS*DW-1:0] rsp_rdata;
  logic [NS-1:0]    rsp_err;
  logic [15:0]      conflict_cnt;

  int n_cmp;
  int n_bad;
  int rc [NS];

  bank_ram_xbar dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_bank     (req_bank),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int s, input logic we, input logic [BW-1:0] bank,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    req_valid[s]           = 1'b1;
    req_we[s]              = we;
    req_bank[s*BW +: BW]   = bank;
    req_addr[s*AW +: AW]   = addr;
    req_wdata[s*DW +: DW]  = wd;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd(input int s);
    return rsp_rdata[s*DW +: DW];
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int s = 0; s < NS; s++) rc[s] = 0;
    rstn      = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_bank  = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state; a request during reset must not be accepted
    step();
    set_req(0, 1'b0, 3'd0, 9'd0, 32'h0);
    #1;
    chk("rst_ready",   32'(req_ready),    32'h0);
    chk("rst_rsp_vld", 32'(rsp_valid),    32'h0);
    chk("rst_rsp_err", 32'(rsp_err),      32'h0);
    chk("rst_rdata0",  rd(0),             32'h0);
    chk("rst_cnt",     32'(conflict_cnt), 32'h0);
    step();
    clr();
    rstn = 1'b1;
    step();

    // Write then read bank 2 row 5 from slot 0
    set_req(0, 1'b1, 3'd2, 9'd5, 32'hDEADBEEF);
    #1 chk("wr_ready", 32'(req_ready), 32'h1);
    step();
    clr();
    set_req(0, 1'b0, 3'd2, 9'd5, 32'h0);
    #1 chk("rd_ready", 32'(req_ready), 32'h1);
    step();
    clr();
    chk("rd_lat1_vld", 32'(rsp_valid), 32'h0);
    step();
    chk("rd_vld",   32'(rsp_valid), 32'h1);
    chk("rd_data",  rd(0),          32'hDEADBEEF);
    chk("rd_err",   32'(rsp_err),   32'h0);
    step();
    chk("rd_pulse", 32'(rsp_valid), 32'h0);

    // Seed bank 1 rows 0..3 from slot 3 so bank 1's pointer ends at 0
    for (int a = 0; a < 4; a++) begin
      set_req(3, 1'b1, 3'd1, AW'(a), 32'h1000 + 32'(a));
      step();
    end
    clr();
    step();

    // Four slots contend for bank 1 for 8 cycles: grants rotate 0,1,2,3
    for (int s = 0; s < NS; s++) set_req(s, 1'b0, 3'd1, AW'(s), 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1) << (i % 4));
      step();
      chk("rr_vld", 32'(rsp_valid), (i >= 1) ? (32'(1) << ((i - 1) % 4)) : 32'h0);
      if (i >= 1) chk("rr_data", rd((i - 1) % 4), 32'h1000 + 32'((i - 1) % 4));
      for (int s = 0; s < NS; s++) if (rsp_valid[s]) rc[s]++;
    end
    clr();
    step();
    chk("rr_last_vld",  32'(rsp_valid), 32'h8);
    chk("rr_last_data", rd(3),          32'h1003);
    for (int s = 0; s < NS; s++) if (rsp_valid[s]) rc[s]++;
    for (int s = 0; s < NS; s++) chk("rr_rsp_count", 32'(rc[s]), 32'd2);
    chk("rr_cnt", 32'(conflict_cnt), 32'd24);
    step();
    chk("rr_idle", 32'(rsp_valid), 32'h0);

    // Four slots to four distinct banks in one cycle
    for (int s = 0; s < NS; s++) set_req(s, 1'b0, BW'(s), 9'd5, 32'h0);
    #1 chk("par_ready", 32'(req_ready), 32'hF);
    step();
    clr();
    chk("par_lat1_vld", 32'(rsp_valid), 32'h0);
    step();
    chk("par_vld",   32'(rsp_valid),    32'hF);
    chk("par_data2", rd(2),             32'hDEADBEEF);
    chk("par_cnt",   32'(conflict_cnt), 32'd24);
    step();

    // Out-of-range bank 7: read errors, write is dropped
    set_req(2, 1'b0, 3'd7, 9'd5, 32'h0);
    #1 chk("oor_rd_ready", 32'(req_ready), 32'h4);
    step();
    clr();
    step();
    chk("oor_vld",   32'(rsp_valid), 32'h4);
    chk("oor_err",   32'(rsp_err),   32'h4);
    chk("oor_rdata", rd(2),          32'h0);
    set_req(2, 1'b1, 3'd7, 9'd5, 32'h12345678);
    #1 chk("oor_wr_ready", 32'(req_ready), 32'h4);
    step();
    clr();
    chk("oor_wr_vld1", 32'(rsp_valid), 32'h0);
    step();
    chk("oor_wr_vld2", 32'(rsp_valid), 32'h0);
    set_req(0, 1'b0, 3'd2, 9'd5, 32'h0);
    step();
    clr();
    step();
    chk("oor_bank2_intact", rd(0), 32'hDEADBEEF);
    chk("oor_cnt", 32'(conflict_cnt), 32'd24);

    // Back-to-back reads on slot 1, then reset with reads in flight
    for (int a = 0; a < 4; a++) begin
      set_req(1, 1'b0, 3'd0, AW'(a), 32'h0);
      step();
    end
    chk("b2b_vld", 32'(rsp_valid), 32'h2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready),    32'h0);
    chk("mid_rst_vld",   32'(rsp_valid),    32'h0);
    chk("mid_rst_err",   32'(rsp_err),      32'h0);
    chk("mid_rst_rdata", rd(1),             32'h0);
    chk("mid_rst_cnt",   32'(conflict_cnt), 32'h0);
    step();
    clr();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_vld", 32'(rsp_valid), 32'h0);
    end

    // Pointers reset to 0: slot 0 wins bank 2 over slot 1
    set_req(0, 1'b0, 3'd2, 9'd5, 32'h0);
    set_req(1, 1'b0, 3'd2, 9'd5, 32'h0);
    #1 chk("ptr_rst_ready", 32'(req_ready), 32'h1);
    step();
    clr();
    chk("ptr_rst_cnt", 32'(conflict_cnt), 32'd1);
    step();

    // Saturation: 3 denials per cycle starting from 1
    for (int s = 0; s < NS; s++) set_req(s, 1'b0, 3'd0, 9'd0, 32'h0);
    for (int i = 0; i < 10000; i++) step();
    chk("sat_mid", 32'(conflict_cnt), 32'd30001);
    for (int i = 0; i < 11844; i++) step();
    chk("sat_pre", 32'(conflict_cnt), 32'd65533);
    step();
    chk("sat_hit", 32'(conflict_cnt), 32'hFFFF);
    for (int i = 0; i < 1500; i++) step();
    chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    clr();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
